prio_coder_n: RTL and testbench
===============================

Name: prio_coder_n

Overview:
- Parametrised, registered priority encoder with sticky request capture, per-input masking and a valid/ready output handshake.
- Generalises the fixed 8-to-3 one-hot encoder to N inputs.
- Handles multi-hot inputs by priority (fixed lowest, fixed highest, or round-robin) instead of defaulting to 0.
- Serves as the request-collection front end for interrupt and event dispatch logic.

Parameters:
- N, 8: number of request inputs, N >= 1.
- PRIO_HIGH, 0: 0 = lowest index wins; 1 = highest index wins. Ignored when RR=1.
- RR, 0: 1 = round-robin; the search starts one above the last acknowledged index and wraps.
- W (localparam, not overridable), max(1, clog2(N)): width of RES.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- INP  input  N  request bits; a 1 sets the matching pending bit at the next edge.
- CLR  input  N  software clear of pending bits.
- MSK  input  N  1 = input not eligible for selection; its pending bit is still held.
- RDY  input  1  consumer ready.
- VLD  output  1  RES is valid.
- RES  output  W  index of the offered request.
- PND  output  N  pending register, direct view.
- MUL  output  1  registered; 1 when two or more unmasked bits are pending.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-offer):
  - PND=0, VLD=0, RES=0, MUL=0, state IDLE.
  - RR pointer = N-1, so the first search starts at index 0.
- Pending update at each edge: P_next = (P | INP) & ~CLR & ~ACK.
  - ACK = one-hot(RES) when VLD&RDY, else 0.
  - Priority on the same bit: CLR > INP > ACK. A new request on the bit being acknowledged re-sets it.
- Eligible set E = P & ~MSK. Selection uses the registered P, not INP.
- Latency: request on INP at edge k -> PND bit set at edge k -> VLD=1 with RES at edge k+1.
- State IDLE (VLD=0):
  - If E != 0: load RES = pick(E), set VLD=1, go to OFFER.
  - Otherwise stay in IDLE.
- State OFFER (VLD=1):
  - While RDY=0: RES and VLD hold stable. Newly arriving higher-priority requests and MSK changes do not alter RES.
  - If CLR clears the offered bit while RDY=0: VLD=0 at the next edge, return to IDLE. This is a withdraw, not an ack, and the RR pointer is unchanged.
  - On VLD&RDY:
    - RR pointer <= RES.
    - Let E' = E with the acked bit removed. If E' != 0, load RES = pick(E') with the updated pointer and stay in OFFER. This gives one grant per cycle.
    - Otherwise VLD=0 and go to IDLE.
    - A simultaneous INP re-set of the acked bit is not offered in the same cycle; it becomes eligible from the next evaluation.
- pick():
  - Fixed-priority modes: scan per PRIO_HIGH.
  - RR mode: first set bit at indices ptr+1 … N-1, then 0 … ptr.
  - pick is only ever called with a non-empty set.
- Width rules:
  - For N not a power of 2, RES only takes values 0..N-1.
  - For N=1, RES is 1 bit and always 0.
- MUL = (popcount(E) >= 2), registered each cycle, independent of state.

Decomposition:
- Package coder_pkg:
  - Safe clog2 function returning min 1.
  - Mode constants PRIO_LOW=0, PRIO_HIGH=1.
  - State encoding IDLE/OFFER.
- Sub-module prio_pick_n: combinational; inputs are the set [N], start pointer [W] and direction; outputs are index [W] and found.
  - Instantiated once for the IDLE/hold load path and once for the post-ack E' path.

Test Plan:
- Reset: hold RST_N=0 with INP=8'hFF -> VLD=0, RES=0, PND=0, MUL=0. Release -> PND=8'hFF one edge later.
- Fixed-low priority: PRIO_HIGH=0, RDY=1, one-cycle pulse INP=8'b0010_0100 -> next cycle VLD=1, RES=2, MUL=1; following cycle RES=5, MUL=0; then VLD=0, PND=0.
- Hold and CLR withdraw:
  - RDY=0, pulse INP=8'h10 -> RES=4 held; pulse INP=8'h01 -> RES stays 4.
  - CLR=8'h10 -> VLD=0 at the next edge, then RES=0 is offered.
- Round-robin: RR=1, INP held 8'h81, RDY=1 -> RES sequence 0,7,0,7 with VLD continuously 1.
- Mask: MSK=8'h01, pulse INP=8'h03, RDY=1 -> RES=1 only, then VLD=0, PND=8'h01. Clear MSK -> RES=0 offered.
- Async reset mid-offer: in OFFER with RES=3, drop RST_N between edges -> VLD=0 and PND=0 immediately, without waiting for CLK.

Source files
------------

// File: rtl/coder_pkg.sv
// Shared definitions for the N-input priority coder: width helper,
// scan-direction constants and the offer FSM state encoding.
package coder_pkg;

    // Scan direction values understood by prio_pick_n.
    localparam int PRIO_LOW  = 0;
    localparam int PRIO_HIGH = 1;

    // Offer FSM: IDLE has nothing on the output, OFFER presents RES with VLD=1.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    // clog2 that never returns less than 1, so a single-input coder still
    // has a one-bit index port.
    function automatic int safe_clog2(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/prio_pick_n.sv
// Combinational circular scan: returns the first set bit of set_i found by
// walking from start_i upward (dir_i = PRIO_LOW) or downward
// (dir_i = PRIO_HIGH), wrapping around the N positions.
module prio_pick_n
    import coder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = safe_clog2(N)
) (
    input  logic [N-1:0] set_i,
    input  logic [W-1:0] start_i,
    input  logic         dir_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // Walk offsets from farthest to nearest so the nearest hit is the last
    // assignment and therefore wins.
    always_comb begin
        int pos;
        logic [W-1:0] pos_w;
        idx_o   = '0;
        found_o = 1'b0;
        pos     = 0;
        pos_w   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (dir_i == 1'(PRIO_HIGH)) begin
                pos = int'(start_i) - k;
                if (pos < 0) begin
                    pos = pos + N;
                end
            end else begin
                pos = int'(start_i) + k;
                if (pos >= N) begin
                    pos = pos - N;
                end
            end
            pos_w = W'(pos);
            if (set_i[pos_w]) begin
                idx_o   = pos_w;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_coder_n.sv
// Registered N-input priority encoder with sticky pending capture, per-input
// masking and a valid/ready offer port. Selection is fixed-lowest,
// fixed-highest or round-robin; one grant can be taken per clock.
module prio_coder_n #(
    parameter int N         = 8,
    parameter int PRIO_HIGH = 0,
    parameter int RR        = 0,
    localparam int W        = coder_pkg::safe_clog2(N)
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [N-1:0] INP,
    input  logic [N-1:0] CLR,
    input  logic [N-1:0] MSK,
    input  logic         RDY,
    output logic         VLD,
    output logic [W-1:0] RES,
    output logic [N-1:0] PND,
    output logic         MUL
);

    import coder_pkg::state_e;
    import coder_pkg::IDLE;
    import coder_pkg::OFFER;

    localparam logic [W-1:0] LAST = W'(N - 1);

    // Round-robin and fixed-low both scan upward; only fixed-high scans down.
    localparam logic SCAN_DIR = ((RR == 0) && (PRIO_HIGH != 0)) ? 1'b1 : 1'b0;

    state_e         state_q, state_d;
    logic [W-1:0]   res_q, res_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   pnd_q, pnd_d;
    logic           mul_q, mul_d;

    logic [N-1:0]   ack;
    logic [N-1:0]   elig;
    logic [N-1:0]   elig_post;
    logic [W-1:0]   start_load;
    logic [W-1:0]   start_post;
    logic [W-1:0]   idx_load;
    logic [W-1:0]   idx_post;
    logic           found_load;
    logic           found_post;
    logic           take;

    // A grant is taken whenever an offer is on the port and the consumer is ready.
    assign take = (state_q == OFFER) && RDY;

    // Per-bit acknowledge decode and eligibility (registered pending, unmasked).
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign ack[gi]       = take && (res_q == W'(gi));
            assign elig[gi]      = pnd_q[gi] && !MSK[gi];
            assign elig_post[gi] = elig[gi] && !ack[gi];
        end
    endgenerate

    // Round-robin resumes one above the last grant; the post-ack path already
    // treats the bit being granted now as the new pointer.
    function automatic logic [W-1:0] next_idx(input logic [W-1:0] idx);
        return (idx == LAST) ? '0 : W'(idx + 1'b1);
    endfunction

    generate
        if (RR != 0) begin : g_start_rr
            assign start_load = next_idx(ptr_q);
            assign start_post = next_idx(res_q);
        end else if (PRIO_HIGH != 0) begin : g_start_high
            assign start_load = LAST;
            assign start_post = LAST;
        end else begin : g_start_low
            assign start_load = '0;
            assign start_post = '0;
        end
    endgenerate

    // Picker for a fresh offer out of IDLE.
    prio_pick_n #(.N(N), .W(W)) u_pick_load (
        .set_i   (elig),
        .start_i (start_load),
        .dir_i   (SCAN_DIR),
        .idx_o   (idx_load),
        .found_o (found_load)
    );

    // Picker for the back-to-back offer that follows a grant.
    prio_pick_n #(.N(N), .W(W)) u_pick_post (
        .set_i   (elig_post),
        .start_i (start_post),
        .dir_i   (SCAN_DIR),
        .idx_o   (idx_post),
        .found_o (found_post)
    );

    // Pending update: clear beats a new request, a new request beats the ack.
    // MUL tracks the pending view it is registered alongside.
    always_comb begin
        pnd_d = '0;
        for (int i = 0; i < N; i++) begin
            pnd_d[i] = !CLR[i] && (INP[i] || (pnd_q[i] && !ack[i]));
        end
        mul_d = ($countones(pnd_d & ~MSK) >= 2);
    end

    // Offer FSM: load from IDLE, hold while stalled, withdraw on clear,
    // chain the next pick on each grant.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found_load) begin
                    res_d   = idx_load;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (RDY) begin
                    ptr_d = res_q;
                    if (found_post) begin
                        res_d = idx_post;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (CLR[res_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset parks the pointer at N-1 so the first search starts at 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            res_q   <= '0;
            ptr_q   <= LAST;
            pnd_q   <= '0;
            mul_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ptr_q   <= ptr_d;
            pnd_q   <= pnd_d;
            mul_q   <= mul_d;
        end
    end

    assign VLD = (state_q == OFFER);
    assign RES = res_q;
    assign PND = pnd_q;
    assign MUL = mul_q;

endmodule

// File: tb/tb_prio_coder_n.sv
// Directed bench for prio_coder_n: fixed-low, round-robin, fixed-high on a
// non-power-of-two width, and a single-input instance.
module tb_prio_coder_n;

    logic clk;
    logic rst_n;

    // Default instance: N=8, fixed lowest.
    logic [7:0] a_inp, a_clr, a_msk, a_pnd;
    logic       a_rdy, a_vld, a_mul;
    logic [2:0] a_res;

    // Round-robin instance: N=8.
    logic [7:0] r_inp, r_clr, r_msk, r_pnd;
    logic       r_rdy, r_vld, r_mul;
    logic [2:0] r_res;

    // Fixed highest, N=5.
    logic [4:0] h_inp, h_clr, h_msk, h_pnd;
    logic       h_rdy, h_vld, h_mul;
    logic [2:0] h_res;

    // Single input, N=1.
    logic [0:0] s_inp, s_clr, s_msk, s_pnd;
    logic       s_rdy, s_vld, s_mul;
    logic [0:0] s_res;

    int n_chk;
    int n_fail;

    prio_coder_n #(.N(8), .PRIO_HIGH(0), .RR(0)) dut_a (
        .CLK(clk), .RST_N(rst_n), .INP(a_inp), .CLR(a_clr), .MSK(a_msk), .RDY(a_rdy),
        .VLD(a_vld), .RES(a_res), .PND(a_pnd), .MUL(a_mul)
    );

    prio_coder_n #(.N(8), .PRIO_HIGH(0), .RR(1)) dut_r (
        .CLK(clk), .RST_N(rst_n), .INP(r_inp), .CLR(r_clr), .MSK(r_msk), .RDY(r_rdy),
        .VLD(r_vld), .RES(r_res), .PND(r_pnd), .MUL(r_mul)
    );

    prio_coder_n #(.N(5), .PRIO_HIGH(1), .RR(0)) dut_h (
        .CLK(clk), .RST_N(rst_n), .INP(h_inp), .CLR(h_clr), .MSK(h_msk), .RDY(h_rdy),
        .VLD(h_vld), .RES(h_res), .PND(h_pnd), .MUL(h_mul)
    );

    prio_coder_n #(.N(1), .PRIO_HIGH(0), .RR(0)) dut_s (
        .CLK(clk), .RST_N(rst_n), .INP(s_inp), .CLR(s_clr), .MSK(s_msk), .RDY(s_rdy),
        .VLD(s_vld), .RES(s_res), .PND(s_pnd), .MUL(s_mul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_inp = '0; a_clr = '0; a_msk = '0; a_rdy = 1'b0;
        r_inp = '0; r_clr = '0; r_msk = '0; r_rdy = 1'b0;
        h_inp = '0; h_clr = '0; h_msk = '0; h_rdy = 1'b0;
        s_inp = '0; s_clr = '0; s_msk = '0; s_rdy = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_inp = 8'hFF;
        tick();
        tick();
        n_chk++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %0h want 0", a_vld); end
        n_chk++; if (a_res !== 3'd0) begin n_fail++; $display("FAIL rst_res: got %0h want 0", a_res); end
        n_chk++; if (a_pnd !== 8'h00) begin n_fail++; $display("FAIL rst_pnd: got %0h want 0", a_pnd); end
        n_chk++; if (a_mul !== 1'b0) begin n_fail++; $display("FAIL rst_mul: got %0h want 0", a_mul); end
        rst_n = 1'b1;
        tick();
        n_chk++; if (a_pnd !== 8'hFF) begin n_fail++; $display("FAIL rel_pnd: got %0h want ff", a_pnd); end
        n_chk++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL rel_vld: got %0h want 0", a_vld); end
        n_chk++; if (a_mul !== 1'b1) begin n_fail++; $display("FAIL rel_mul: got %0h want 1", a_mul); end
        $display("test_reset: done");
        do_reset();
    endtask

    task automatic test_fixed_low();
        a_rdy = 1'b1;
        a_inp = 8'b0010_0100;
        tick();
        a_inp = '0;
        n_chk++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL low_lat_vld: got %0h want 0", a_vld); end
        tick();
        n_chk++; if (a_vld !== 1'b1) begin n_fail++; $display("FAIL low_vld1: got %0h want 1", a_vld); end
        n_chk++; if (a_res !== 3'd2) begin n_fail++; $display("FAIL low_res1: got %0d want 2", a_res); end
        n_chk++; if (a_mul !== 1'b1) begin n_fail++; $display("FAIL low_mul1: got %0h want 1", a_mul); end
        tick();
        n_chk++; if (a_res !== 3'd5) begin n_fail++; $display("FAIL low_res2: got %0d want 5", a_res); end
        n_chk++; if (a_vld !== 1'b1) begin n_fail++; $display("FAIL low_vld2: got %0h want 1", a_vld); end
        n_chk++; if (a_mul !== 1'b0) begin n_fail++; $display("FAIL low_mul2: got %0h want 0", a_mul); end
        n_chk++; if (a_pnd !== 8'h20) begin n_fail++; $display("FAIL low_pnd2: got %0h want 20", a_pnd); end
        tick();
        n_chk++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL low_vld3: got %0h want 0", a_vld); end
        n_chk++; if (a_pnd !== 8'h00) begin n_fail++; $display("FAIL low_pnd3: got %0h want 0", a_pnd); end
        $display("test_fixed_low: done");
        do_reset();
    endtask

    task automatic test_hold_withdraw();
        a_rdy = 1'b0;
        a_inp = 8'h10;
        tick();
        a_inp = '0;
        tick();
        n_chk++; if (a_res !== 3'd4 || a_vld !== 1'b1) begin n_fail++; $display("FAIL hold_offer: got vld %0h res %0d want vld 1 res 4", a_vld, a_res); end
        a_inp = 8'h01;
        tick();
        a_inp = '0;
        tick();
        n_chk++; if (a_res !== 3'd4 || a_vld !== 1'b1) begin n_fail++; $display("FAIL hold_stable: got vld %0h res %0d want vld 1 res 4", a_vld, a_res); end
        n_chk++; if (a_pnd !== 8'h11) begin n_fail++; $display("FAIL hold_pnd: got %0h want 11", a_pnd); end
        a_clr = 8'h10;
        tick();
        a_clr = '0;
        n_chk++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL wd_vld: got %0h want 0", a_vld); end
        n_chk++; if (a_pnd !== 8'h01) begin n_fail++; $display("FAIL wd_pnd: got %0h want 01", a_pnd); end
        tick();
        n_chk++; if (a_res !== 3'd0 || a_vld !== 1'b1) begin n_fail++; $display("FAIL wd_next: got vld %0h res %0d want vld 1 res 0", a_vld, a_res); end
        a_rdy = 1'b1;
        tick();
        n_chk++; if (a_vld !== 1'b0 || a_pnd !== 8'h00) begin n_fail++; $display("FAIL wd_drain: got vld %0h pnd %0h want vld 0 pnd 0", a_vld, a_pnd); end
        $display("test_hold_withdraw: done");
        do_reset();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'd0; exp_seq[1] = 3'd7; exp_seq[2] = 3'd0; exp_seq[3] = 3'd7;
        r_rdy = 1'b1;
        r_inp = 8'h81;
        tick();
        n_chk++; if (r_vld !== 1'b0) begin n_fail++; $display("FAIL rr_lat: got vld %0h want 0", r_vld); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (r_vld !== 1'b1 || r_res !== exp_seq[i]) begin n_fail++; $display("FAIL rr_seq%0d: got vld %0h res %0d want vld 1 res %0d", i, r_vld, r_res, exp_seq[i]); end
        end
        $display("test_round_robin: done");
        do_reset();
    endtask

    task automatic test_mask();
        a_rdy = 1'b1;
        a_msk = 8'h01;
        a_inp = 8'h03;
        tick();
        a_inp = '0;
        n_chk++; if (a_mul !== 1'b0) begin n_fail++; $display("FAIL msk_mul: got %0h want 0", a_mul); end
        tick();
        n_chk++; if (a_vld !== 1'b1 || a_res !== 3'd1) begin n_fail++; $display("FAIL msk_res: got vld %0h res %0d want vld 1 res 1", a_vld, a_res); end
        tick();
        n_chk++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL msk_idle: got vld %0h want 0", a_vld); end
        n_chk++; if (a_pnd !== 8'h01) begin n_fail++; $display("FAIL msk_pnd: got %0h want 01", a_pnd); end
        a_msk = '0;
        tick();
        n_chk++; if (a_vld !== 1'b1 || a_res !== 3'd0) begin n_fail++; $display("FAIL msk_unmask: got vld %0h res %0d want vld 1 res 0", a_vld, a_res); end
        tick();
        n_chk++; if (a_vld !== 1'b0 || a_pnd !== 8'h00) begin n_fail++; $display("FAIL msk_drain: got vld %0h pnd %0h want vld 0 pnd 0", a_vld, a_pnd); end
        $display("test_mask: done");
        do_reset();
    endtask

    task automatic test_prio_high_n5();
        logic [2:0] exp_seq [3];
        exp_seq[0] = 3'd4; exp_seq[1] = 3'd1; exp_seq[2] = 3'd0;
        h_rdy = 1'b1;
        h_inp = 5'b10011;
        tick();
        h_inp = '0;
        n_chk++; if (h_pnd !== 5'b10011 || h_mul !== 1'b1) begin n_fail++; $display("FAIL hi_pnd: got pnd %0h mul %0h want pnd 13 mul 1", h_pnd, h_mul); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (h_vld !== 1'b1 || h_res !== exp_seq[i]) begin n_fail++; $display("FAIL hi_seq%0d: got vld %0h res %0d want vld 1 res %0d", i, h_vld, h_res, exp_seq[i]); end
        end
        tick();
        n_chk++; if (h_vld !== 1'b0 || h_pnd !== 5'b00000) begin n_fail++; $display("FAIL hi_drain: got vld %0h pnd %0h want vld 0 pnd 0", h_vld, h_pnd); end
        $display("test_prio_high_n5: done");
        do_reset();
    endtask

    task automatic test_single_input();
        s_rdy = 1'b1;
        s_inp = 1'b1;
        tick();
        s_inp = 1'b0;
        tick();
        n_chk++; if (s_vld !== 1'b1 || s_res !== 1'b0 || s_mul !== 1'b0) begin n_fail++; $display("FAIL one_offer: got vld %0h res %0h mul %0h want 1 0 0", s_vld, s_res, s_mul); end
        tick();
        n_chk++; if (s_vld !== 1'b0 || s_pnd !== 1'b0) begin n_fail++; $display("FAIL one_drain: got vld %0h pnd %0h want 0 0", s_vld, s_pnd); end
        $display("test_single_input: done");
        do_reset();
    endtask

    task automatic test_async_reset();
        a_rdy = 1'b0;
        a_inp = 8'h08;
        tick();
        a_inp = '0;
        tick();
        n_chk++; if (a_vld !== 1'b1 || a_res !== 3'd3) begin n_fail++; $display("FAIL ar_offer: got vld %0h res %0d want vld 1 res 3", a_vld, a_res); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (a_vld !== 1'b0 || a_pnd !== 8'h00 || a_res !== 3'd0) begin n_fail++; $display("FAIL ar_clear: got vld %0h pnd %0h res %0d want 0 0 0", a_vld, a_pnd, a_res); end
        #1;
        rst_n = 1'b1;
        $display("test_async_reset: done");
        do_reset();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        do_reset();
        test_reset();
        test_fixed_low();
        test_hold_withdraw();
        test_round_robin();
        test_mask();
        test_prio_high_n5();
        test_single_input();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
